// File: rtl/write_test_pkg.sv
// Shared definitions for the pipe write-test sequencer: FSM states, status
// byte layout and counter widths.
package write_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int CLK_W    = 64;
    localparam int WORD_W   = 32;
    localparam int TMR_W    = 32;
    localparam int STATUS_W = 8;

    // Bit positions inside status; bit 0 is reserved and reads as zero
    localparam int STAT_BUSY     = 7;
    localparam int STAT_DONE     = 6;
    localparam int STAT_PASS     = 5;
    localparam int STAT_TIMEOUT  = 4;
    localparam int STAT_OVERRUN  = 3;
    localparam int STAT_CFG_ERR  = 2;
    localparam int STAT_ABORTED  = 1;

    function automatic logic is_active(input state_t s);
        return (s == S_FLUSH) || (s == S_ARMED) || (s == S_RUN) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/write_test_sequencer_if.sv
// Control, pipe/FIFO event and result signals between a host and the
// write-test sequencer.
interface write_test_sequencer_if;
    import write_test_pkg::*;

    logic                start;
    logic                abort;
    logic [WORD_W-1:0]   word_target;
    logic                pipe_write;
    logic                fifo_valid;
    logic                fifo_empty;
    logic [31:0]         err_count;
    logic                fifo_rst;
    logic                pattern_rst;
    logic                timer_run;
    logic [CLK_W-1:0]    clk_counts;
    logic [WORD_W-1:0]   words_in;
    logic [WORD_W-1:0]   words_checked;
    logic [STATUS_W-1:0] status;

    modport slave (
        input  start, abort, word_target, pipe_write, fifo_valid, fifo_empty, err_count,
        output fifo_rst, pattern_rst, timer_run, clk_counts, words_in, words_checked, status
    );

    modport master (
        output start, abort, word_target, pipe_write, fifo_valid, fifo_empty, err_count,
        input  fifo_rst, pattern_rst, timer_run, clk_counts, words_in, words_checked, status
    );

endinterface

// File: rtl/write_test_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/write_test_sequencer.sv
// Sequences one pipe write throughput test: flush, wait for first write,
// time the transfer until every word is checked, then report status.
module write_test_sequencer
    import write_test_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input logic              okClk,
    input logic              reset,
    write_test_sequencer_if.slave bus
);

    localparam int FW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [FW-1:0]    FLUSH_LAST = FW'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    state_t            state;
    logic [WORD_W-1:0] target;
    logic [FW-1:0]     flush_cnt;
    logic              pass_r, timeout_r, overrun_r, cfg_err_r, aborted_r;

    logic [CLK_W-1:0]  clk_cnt;
    logic [WORD_W-1:0] win_cnt;
    logic [WORD_W-1:0] chk_cnt;
    logic [TMR_W-1:0]  drain_tmr;

    logic              idle_or_done, start_ok, abort_ok, counting;
    logic              write_ok, clk_en, chk_en, cnt_clr;
    logic              last_write, drain_done, drain_expired, overrun_now, clean;
    logic [WORD_W:0]   chk_next;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign start_ok     = bus.start && idle_or_done;
    assign abort_ok     = bus.abort && !idle_or_done;
    assign counting     = (state == S_RUN) || (state == S_DRAIN);
    assign cnt_clr      = reset || start_ok;

    // Abort freezes every counter in the very cycle it arrives
    assign write_ok = bus.pipe_write && ((state == S_ARMED) || counting) && !abort_ok;
    assign clk_en   = (counting || ((state == S_ARMED) && bus.pipe_write)) && !abort_ok;
    assign chk_en   = bus.fifo_valid && counting && !abort_ok;

    // Look-ahead so the write that reaches the target moves straight to DRAIN
    assign last_write    = write_ok && (({1'b0, win_cnt} + (WORD_W+1)'(1)) == {1'b0, target});
    assign chk_next      = {1'b0, chk_cnt} + (WORD_W+1)'(chk_en);
    assign drain_done    = (chk_next == {2'b00, target[WORD_W-1:1]}) && bus.fifo_empty;
    assign drain_expired = (drain_tmr == DRAIN_LAST);
    assign overrun_now   = (state == S_DRAIN) && write_ok;
    assign clean         = (bus.err_count == '0) && !overrun_r && !overrun_now;

    sat_counter #(.WIDTH(CLK_W)) u_clk_cnt (
        .clk(okClk), .clr(cnt_clr), .en(clk_en), .q(clk_cnt)
    );

    sat_counter #(.WIDTH(WORD_W)) u_win_cnt (
        .clk(okClk), .clr(cnt_clr), .en(write_ok), .q(win_cnt)
    );

    sat_counter #(.WIDTH(WORD_W)) u_chk_cnt (
        .clk(okClk), .clr(cnt_clr), .en(chk_en), .q(chk_cnt)
    );

    sat_counter #(.WIDTH(TMR_W)) u_drain_tmr (
        .clk(okClk), .clr(reset || (state != S_DRAIN)), .en(state == S_DRAIN), .q(drain_tmr)
    );

    always_ff @(posedge okClk) begin
        if (reset) begin
            state     <= S_IDLE;
            target    <= '0;
            flush_cnt <= '0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            overrun_r <= 1'b0;
            cfg_err_r <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state     <= S_FLUSH;
                        target    <= bus.word_target;
                        flush_cnt <= '0;
                        pass_r    <= 1'b0;
                        timeout_r <= 1'b0;
                        overrun_r <= 1'b0;
                        cfg_err_r <= 1'b0;
                        aborted_r <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (bus.abort) begin
                        state     <= S_DONE;
                        aborted_r <= 1'b1;
                    end else if (flush_cnt == FLUSH_LAST) begin
                        // Odd targets cannot fill whole 64-bit FIFO words
                        if (target[0]) begin
                            state     <= S_DONE;
                            cfg_err_r <= 1'b1;
                        end else if (target == '0) begin
                            state  <= S_DONE;
                            pass_r <= (bus.err_count == '0);
                        end else begin
                            state <= S_ARMED;
                        end
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                S_ARMED: begin
                    if (bus.abort) begin
                        state     <= S_DONE;
                        aborted_r <= 1'b1;
                    end else if (bus.pipe_write) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state     <= S_DONE;
                        aborted_r <= 1'b1;
                    end else if (last_write) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.abort) begin
                        state     <= S_DONE;
                        aborted_r <= 1'b1;
                    end else begin
                        if (overrun_now) begin
                            overrun_r <= 1'b1;
                        end
                        if (drain_done) begin
                            state  <= S_DONE;
                            pass_r <= clean;
                        end else if (drain_expired) begin
                            state     <= S_DONE;
                            timeout_r <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.status               = '0;
        bus.status[STAT_BUSY]    = is_active(state);
        bus.status[STAT_DONE]    = (state == S_DONE);
        bus.status[STAT_PASS]    = pass_r;
        bus.status[STAT_TIMEOUT] = timeout_r;
        bus.status[STAT_OVERRUN] = overrun_r;
        bus.status[STAT_CFG_ERR] = cfg_err_r;
        bus.status[STAT_ABORTED] = aborted_r;
    end

    assign bus.fifo_rst      = reset || (state == S_FLUSH);
    assign bus.pattern_rst   = reset || (state == S_FLUSH);
    assign bus.timer_run     = counting;
    assign bus.clk_counts    = clk_cnt;
    assign bus.words_in      = win_cnt;
    assign bus.words_checked = chk_cnt;

endmodule

// File: tb/tb_write_test_sequencer.sv
// Scenario bench for write_test_sequencer; expectations come from the
// test-level rules (write/check counts, cycle spans), not from the FSM.
module tb_write_test_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int DRAIN_TIMEOUT = 4096;

    // status = {busy, done, pass, timeout, overrun, cfg_err, aborted, 0}
    localparam logic [7:0] ST_ARMED   = 8'h80;
    localparam logic [7:0] ST_PASS    = 8'h60;
    localparam logic [7:0] ST_TIMEOUT = 8'h50;
    localparam logic [7:0] ST_OVERRUN = 8'h48;
    localparam logic [7:0] ST_CFGERR  = 8'h44;
    localparam logic [7:0] ST_ABORTED = 8'h42;
    localparam logic [7:0] ST_FAILED  = 8'h40;

    logic okClk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    write_test_sequencer_if bus();

    write_test_sequencer #(.RST_CYCLES(RST_CYCLES), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
        .okClk(okClk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 okClk = ~okClk;

    task automatic step();
        @(posedge okClk);
        #1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pipe_write = 1'b0;
        bus.fifo_valid = 1'b0;
    endtask

    task automatic drive(input logic pw, input logic fv);
        bus.pipe_write = pw;
        bus.fifo_valid = fv;
        step();
    endtask

    // Start a test and sit out the flush so the sequencer is armed
    task automatic start_armed(input logic [31:0] tgt);
        bus.word_target = tgt;
        bus.start       = 1'b1;
        step();
        repeat (RST_CYCLES) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (bus.fifo_rst !== 1'b1) begin fails++; $display("FAIL rst_fifo_rst: got %b expected 1", bus.fifo_rst); end
        checks++; if (bus.pattern_rst !== 1'b1) begin fails++; $display("FAIL rst_pattern_rst: got %b expected 1", bus.pattern_rst); end
        checks++; if (bus.status !== 8'h00) begin fails++; $display("FAIL rst_status: got %h expected 00", bus.status); end
        checks++; if (bus.clk_counts !== 64'd0) begin fails++; $display("FAIL rst_clk_counts: got %0d expected 0", bus.clk_counts); end
        checks++; if (bus.words_in !== 32'd0 || bus.words_checked !== 32'd0) begin fails++; $display("FAIL rst_words: got %0d/%0d expected 0/0", bus.words_in, bus.words_checked); end
        checks++; if (bus.timer_run !== 1'b0) begin fails++; $display("FAIL rst_timer_run: got %b expected 0", bus.timer_run); end
        reset = 1'b0;
        step();
        checks++; if (bus.fifo_rst !== 1'b0 || bus.status !== 8'h00) begin fails++; $display("FAIL idle_after_rst: got fifo_rst=%b status=%h expected 0/00", bus.fifo_rst, bus.status); end
    endtask

    task automatic test_nominal();
        int nv = 0;
        int last = -1;
        start_armed(32'd2048);
        checks++; if (bus.status !== ST_ARMED || bus.timer_run !== 1'b0) begin fails++; $display("FAIL nom_armed: got status=%h run=%b expected %h/0", bus.status, bus.timer_run, ST_ARMED); end
        for (int c = 0; c <= 2048; c++) begin
            logic fv;
            fv = (c >= 2) && (c % 2 == 0);
            drive(c < 2048, fv);
            if (fv) begin nv++; last = c; end
            if (c == 100) begin
                checks++; if (bus.timer_run !== 1'b1) begin fails++; $display("FAIL nom_timer_run: got %b expected 1", bus.timer_run); end
            end
        end
        checks++; if (bus.status !== ST_PASS) begin fails++; $display("FAIL nom_status: got %h expected %h", bus.status, ST_PASS); end
        checks++; if (bus.words_checked !== 32'(nv)) begin fails++; $display("FAIL nom_words_checked: got %0d expected %0d", bus.words_checked, nv); end
        checks++; if (bus.words_in !== 32'd2048) begin fails++; $display("FAIL nom_words_in: got %0d expected 2048", bus.words_in); end
        checks++; if (bus.clk_counts !== 64'(last + 1)) begin fails++; $display("FAIL nom_clk_counts: got %0d expected %0d", bus.clk_counts, last + 1); end
    endtask

    task automatic test_zero_and_odd();
        logic [31:0] tgts [3];
        tgts[0] = 32'd0;
        tgts[1] = 32'd7;
        tgts[2] = 32'(2 * $urandom_range(1, 1000) + 1);
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            int nflush = 0;
            logic [7:0] exp_st;
            exp_st = (tgts[k] == 0) ? ST_PASS : ST_CFGERR;
            bus.word_target = tgts[k];
            bus.start = 1'b1;
            do begin
                step();
                n++;
                if (bus.fifo_rst === 1'b1) nflush++;
            end while (bus.status[6] !== 1'b1 && n < 50);
            checks++; if (n !== RST_CYCLES + 1) begin fails++; $display("FAIL cfg_latency_%0d: got %0d expected %0d", tgts[k], n, RST_CYCLES + 1); end
            checks++; if (nflush !== RST_CYCLES) begin fails++; $display("FAIL cfg_flush_len_%0d: got %0d expected %0d", tgts[k], nflush, RST_CYCLES); end
            checks++; if (bus.status !== exp_st) begin fails++; $display("FAIL cfg_status_%0d: got %h expected %h", tgts[k], bus.status, exp_st); end
            checks++; if (bus.clk_counts !== 64'd0) begin fails++; $display("FAIL cfg_clk_counts_%0d: got %0d expected 0", tgts[k], bus.clk_counts); end
        end
    endtask

    task automatic test_drain_timeout();
        int nv = 0;
        int n = 0;
        start_armed(32'd16);
        for (int c = 0; c < 16; c++) begin
            logic fv;
            fv = (c >= 2) && (c % 2 == 0) && (nv < 7);
            drive(1'b1, fv);
            if (fv) nv++;
        end
        checks++; if (bus.timer_run !== 1'b1) begin fails++; $display("FAIL to_drain_entry: got run=%b expected 1", bus.timer_run); end
        while (bus.status[6] !== 1'b1 && n < DRAIN_TIMEOUT + 20) begin
            drive(1'b0, 1'b0);
            n++;
        end
        checks++; if (n !== DRAIN_TIMEOUT) begin fails++; $display("FAIL to_cycles: got %0d expected %0d", n, DRAIN_TIMEOUT); end
        checks++; if (bus.status !== ST_TIMEOUT) begin fails++; $display("FAIL to_status: got %h expected %h", bus.status, ST_TIMEOUT); end
        checks++; if (bus.words_checked !== 32'(nv)) begin fails++; $display("FAIL to_words_checked: got %0d expected %0d", bus.words_checked, nv); end
        checks++; if (bus.clk_counts !== 64'(16 + DRAIN_TIMEOUT)) begin fails++; $display("FAIL to_clk_counts: got %0d expected %0d", bus.clk_counts, 16 + DRAIN_TIMEOUT); end
    endtask

    task automatic test_overrun();
        start_armed(32'd8);
        for (int c = 0; c <= 8; c++) drive(1'b1, (c >= 2) && (c % 2 == 0));
        checks++; if (bus.status !== ST_OVERRUN) begin fails++; $display("FAIL ovr_status: got %h expected %h", bus.status, ST_OVERRUN); end
        checks++; if (bus.words_in !== 32'd9) begin fails++; $display("FAIL ovr_words_in: got %0d expected 9", bus.words_in); end
        checks++; if (bus.clk_counts !== 64'd9) begin fails++; $display("FAIL ovr_clk_counts: got %0d expected 9", bus.clk_counts); end
    endtask

    task automatic test_err_count();
        start_armed(32'd8);
        bus.err_count = 32'd3;
        for (int c = 0; c <= 8; c++) drive(c < 8, (c >= 2) && (c % 2 == 0));
        checks++; if (bus.status !== ST_FAILED) begin fails++; $display("FAIL err_status: got %h expected %h", bus.status, ST_FAILED); end
        checks++; if (bus.clk_counts !== 64'd9) begin fails++; $display("FAIL err_clk_counts: got %0d expected 9", bus.clk_counts); end
        bus.err_count = 32'd0;
    endtask

    task automatic test_abort_start();
        start_armed(32'd64);
        for (int c = 0; c < 10; c++) drive(1'b1, (c >= 2) && (c % 2 == 0));
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.word_target = 32'd2;
        drive(1'b1, 1'b1);
        checks++; if (bus.status !== ST_ABORTED) begin fails++; $display("FAIL abort_status: got %h expected %h", bus.status, ST_ABORTED); end
        checks++; if (bus.words_in !== 32'd10 || bus.words_checked !== 32'd4) begin fails++; $display("FAIL abort_words: got %0d/%0d expected 10/4", bus.words_in, bus.words_checked); end
        checks++; if (bus.clk_counts !== 64'd10 || bus.timer_run !== 1'b0) begin fails++; $display("FAIL abort_clk: got %0d run=%b expected 10/0", bus.clk_counts, bus.timer_run); end
        repeat (5) drive(1'b1, 1'b1);
        checks++; if (bus.status !== ST_ABORTED || bus.words_in !== 32'd10 || bus.clk_counts !== 64'd10) begin fails++; $display("FAIL abort_hold: got %h %0d %0d expected %h 10 10", bus.status, bus.words_in, bus.clk_counts, ST_ABORTED); end
        // A fresh start from DONE must clear the frozen results
        bus.word_target = 32'd4;
        bus.start = 1'b1;
        step();
        checks++; if (bus.status !== ST_ARMED || bus.words_in !== 32'd0 || bus.clk_counts !== 64'd0) begin fails++; $display("FAIL restart_clear: got %h %0d %0d expected %h 0 0", bus.status, bus.words_in, bus.clk_counts, ST_ARMED); end
        repeat (RST_CYCLES) step();
        bus.abort = 1'b1;
        step();
        checks++; if (bus.status !== ST_ABORTED) begin fails++; $display("FAIL abort_armed: got %h expected %h", bus.status, ST_ABORTED); end
    endtask

    task automatic test_reset_in_drain();
        start_armed(32'd16);
        for (int c = 0; c < 16; c++) drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        checks++; if (bus.timer_run !== 1'b1 || bus.status !== ST_ARMED) begin fails++; $display("FAIL drain_before_rst: got run=%b status=%h expected 1/%h", bus.timer_run, bus.status, ST_ARMED); end
        reset = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        checks++; if (bus.fifo_rst !== 1'b1 || bus.status !== 8'h00) begin fails++; $display("FAIL rst_drain_out: got fifo_rst=%b status=%h expected 1/00", bus.fifo_rst, bus.status); end
        checks++; if (bus.clk_counts !== 64'd0 || bus.words_in !== 32'd0 || bus.words_checked !== 32'd0) begin fails++; $display("FAIL rst_drain_cnt: got %0d/%0d/%0d expected 0/0/0", bus.clk_counts, bus.words_in, bus.words_checked); end
        reset = 1'b0;
        repeat (10) step();
        checks++; if (bus.status !== 8'h00 || bus.fifo_rst !== 1'b0 || bus.timer_run !== 1'b0) begin fails++; $display("FAIL rst_drain_idle: got status=%h fifo_rst=%b run=%b expected 00/0/0", bus.status, bus.fifo_rst, bus.timer_run); end
    endtask

    // Random write/check schedules; a word may only be checked once both
    // of its halves were written, so the final check always lands in DRAIN.
    task automatic test_random_runs();
        for (int it = 0; it < 4; it++) begin
            int t;
            int w = 0;
            int v = 0;
            int c = 0;
            int endc = -1;
            t = 2 * int'($urandom_range(2, 60));
            start_armed(32'(t));
            repeat ($urandom_range(0, 4)) step();
            while (endc < 0 && c < 2000) begin
                logic pw, fv, fe;
                pw = (w < t) && (c == 0 || $urandom_range(0, 3) != 0);
                fv = (v < w / 2) && ($urandom_range(0, 1) == 1);
                fe = ($urandom_range(0, 3) != 0);
                bus.fifo_empty = fe;
                drive(pw, fv);
                w += int'(pw);
                v += int'(fv);
                if (v == t / 2 && fe) endc = c;
                checks++; if (bus.timer_run !== (endc < 0)) begin fails++; $display("FAIL rnd%0d_timer_run_c%0d: got %b expected %b", it, c, bus.timer_run, endc < 0); end
                c++;
            end
            bus.fifo_empty = 1'b1;
            checks++; if (bus.status !== ST_PASS) begin fails++; $display("FAIL rnd%0d_status: got %h expected %h", it, bus.status, ST_PASS); end
            checks++; if (bus.clk_counts !== 64'(endc + 1)) begin fails++; $display("FAIL rnd%0d_clk_counts: got %0d expected %0d", it, bus.clk_counts, endc + 1); end
            checks++; if (bus.words_in !== 32'(t) || bus.words_checked !== 32'(t / 2)) begin fails++; $display("FAIL rnd%0d_words: got %0d/%0d expected %0d/%0d", it, bus.words_in, bus.words_checked, t, t / 2); end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.word_target = '0;
        bus.pipe_write  = 1'b0;
        bus.fifo_valid  = 1'b0;
        bus.fifo_empty  = 1'b1;
        bus.err_count   = '0;
        test_reset();
        test_nominal();
        test_zero_and_odd();
        test_drain_timeout();
        test_overrun();
        test_err_count();
        test_abort_start();
        test_random_runs();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
